demux_1_to_2_32bit_reg: RTL and testbench
=========================================

// Module: demux_1_to_2_32bit_reg
// PURPOSE
//  Registered 1-to-2 demultiplexer: the steering counterpart of the 2-to-1 select muxes.
//  Accepts one word per cycle on a valid/ready input and routes it to port A (sel=0) or B (sel=1).
//  Each destination has a one-entry output register with its own valid/ready handshake.
//  Sits between a datapath result source and two independent consumers, e.g. writeback vs. store path.
// PARAMETERS
//  WIDTH   32  data width of input and both outputs
//  CNT_W   16  width of per-port transfer counters (only with DEMUX_COUNT_EN)
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst          in   1      asynchronous, active-high reset
//  in_data      in   WIDTH  word to route
//  in_sel       in   1      destination: 0 = port A, 1 = port B
//  in_valid     in   1      in_data/in_sel valid
//  in_ready     out  1      block accepts the word this cycle
//  out_a_data   out  WIDTH  port A held word
//  out_a_valid  out  1      port A slot full
//  out_a_ready  in   1      port A consumer takes word this cycle
//  out_b_data   out  WIDTH  port B held word
//  out_b_valid  out  1      port B slot full
//  out_b_ready  in   1      port B consumer takes word this cycle
//  cnt_a        out  CNT_W  words delivered to A (DEMUX_COUNT_EN only)
//  cnt_b        out  CNT_W  words delivered to B (DEMUX_COUNT_EN only)
// BEHAVIOUR
//  - Reset (async, rst=1): out_a_valid=out_b_valid=0, out_a_data=out_b_data=0, cnt_a=cnt_b=0.
//    Held words are discarded; reset mid-transfer drops in-flight data, no partial state kept.
//  - Per-slot FSM, X in {A,B}: EMPTY (valid=0) / FULL (valid=1).
//    EMPTY -> FULL on accept with in_sel selecting X. FULL -> EMPTY on out_X_ready with no refill.
//    FULL -> FULL on drain + refill same cycle (data replaced, valid stays 1).
//  - in_ready = sel slot EMPTY, or sel slot FULL and its out_X_ready=1.
//    Combinational from in_sel and out_X_ready; the non-selected slot never blocks input.
//  - Accept = in_valid & in_ready. Latency 1: word accepted at edge N visible on out_X_* after N.
//  - Outputs are registered; out_X_data stable while out_X_valid=1 and out_X_ready=0.
//  - Non-selected slot is unaffected by input traffic; A and B drain independently, same cycle allowed.
//  - out_X_data retains last value after drain (not cleared); consumers must qualify with valid.
//  - in_valid=0: no state change except drains. in_sel ignored when in_valid=0.
//  - No reordering within a port; no ordering guarantee between ports.
// CONFIGURATION
//  DEMUX_COUNT_EN defined: cnt_a/cnt_b increment by 1 on each out_X_valid&out_X_ready handshake.
//    Wrap modulo 2^CNT_W (0xFFFF -> 0x0000 at default); both may increment in one cycle.
//  DEMUX_COUNT_EN undefined: cnt_a/cnt_b ports and counter logic absent; behaviour otherwise identical.
// TESTING
//  1 Reset: rst=1 mid-run with both slots FULL -> valids=0, data=0, counters=0 immediately, before clk edge.
//  2 Route: in_data=0xDEADBEEF sel=0, then 0x12345678 sel=1, readies=1
//    -> A shows 0xDEADBEEF one cycle later, B shows 0x12345678 next cycle, each valid 1 cycle.
//  3 Backpressure: out_a_ready=0, send 0x1 sel=0 then 0x2 sel=0
//    -> in_ready=0 on 2nd word, A holds 0x1; raise ready -> 0x1 drains, then 0x2 appears.
//  4 Independence: A full and stalled, send 0xAAAA sel=1 -> in_ready=1, B valid next cycle, A keeps data.
//  5 Drain+refill: A FULL with 0x5, out_a_ready=1 and new 0x6 sel=0 same cycle
//    -> out_a_valid stays 1, out_a_data=0x6 next cycle, no bubble.
//  6 Counter (DEMUX_COUNT_EN, CNT_W=4): 17 handshakes on A, 3 on B -> cnt_a=1 (wrapped), cnt_b=3.

Source files
------------

// File: rtl/demux_1_to_2_32bit_reg.sv
// demux_1_to_2_32bit_reg: registered 1-to-2 steering demux with one-entry slot per output;
// define DEMUX_COUNT_EN to add per-port delivered-word counters cnt_a/cnt_b.
module demux_1_to_2_32bit_reg #(
  parameter int WIDTH = 32
`ifdef DEMUX_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready
`ifdef DEMUX_COUNT_EN
  , output logic [CNT_W-1:0] cnt_a
  , output logic [CNT_W-1:0] cnt_b
`endif
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;
  logic [0:0]       state_a_q, state_a_d, state_b_q, state_b_d;
  logic [WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic             drain_a, drain_b, acc_a, acc_b;
  // Handshake decode: a slot can take a word when empty or when it drains this same cycle.
  always_comb begin
    drain_a  = (state_a_q == S_FULL) & out_a_ready;
    drain_b  = (state_b_q == S_FULL) & out_b_ready;
    in_ready = in_sel ? ((state_b_q == S_EMPTY) | out_b_ready)
                      : ((state_a_q == S_EMPTY) | out_a_ready);
    acc_a    = in_valid & in_ready & ~in_sel;
    acc_b    = in_valid & in_ready & in_sel;
  end
  // Slot next state: a refill wins over a drain so drain+refill keeps the slot full without a bubble.
  always_comb begin
    state_a_d = acc_a ? S_FULL : (drain_a ? S_EMPTY : state_a_q);
    state_b_d = acc_b ? S_FULL : (drain_b ? S_EMPTY : state_b_q);
    data_a_d  = acc_a ? in_data : data_a_q;
    data_b_d  = acc_b ? in_data : data_b_q;
  end
  // Slot registers; held data is kept after a drain and only cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_a_q <= S_EMPTY;
      state_b_q <= S_EMPTY;
      data_a_q  <= '0;
      data_b_q  <= '0;
    end else begin
      state_a_q <= state_a_d;
      state_b_q <= state_b_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
    end
  end
  assign out_a_valid = (state_a_q == S_FULL);
  assign out_b_valid = (state_b_q == S_FULL);
  assign out_a_data  = data_a_q;
  assign out_b_data  = data_b_q;
`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  // Delivered-word counters wrap naturally at 2^CNT_W.
  always_comb begin
    cnt_a_d = cnt_a_q + {{(CNT_W-1){1'b0}}, drain_a};
    cnt_b_d = cnt_b_q + {{(CNT_W-1){1'b0}}, drain_b};
  end
  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end
  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif
endmodule

// File: tb/tb_demux_1_to_2_32bit_reg.sv
// tb_demux_1_to_2_32bit_reg: directed and random checks of the registered 1-to-2 demux against a queue model.
module tb_demux_1_to_2_32bit_reg;
  localparam int CW = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_sel = 1'b0, in_valid = 1'b0, out_a_ready = 1'b0, out_b_ready = 1'b0;
  logic        in_ready, out_a_valid, out_b_valid;
  logic [31:0] out_a_data, out_b_data;
`ifdef DEMUX_COUNT_EN
  logic [CW-1:0] cnt_a, cnt_b;
`endif
  int n_vec = 0, n_err = 0;
  logic [31:0] qa[$], qb[$];
  logic [31:0] la = '0, lb = '0;
  int ca = 0, cb = 0;
  logic exp_rdy, obs_rdy;

  demux_1_to_2_32bit_reg #(
    .WIDTH(32)
`ifdef DEMUX_COUNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_a_data(out_a_data), .out_a_valid(out_a_valid),
    .out_a_ready(out_a_ready), .out_b_data(out_b_data), .out_b_valid(out_b_valid),
    .out_b_ready(out_b_ready)
`ifdef DEMUX_COUNT_EN
    , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model treats each port as a queue holding at most one word.
  task automatic cycle(input logic v, input logic s, input logic [31:0] d, input logic ra, input logic rb);
    in_valid = v; in_sel = s; in_data = d; out_a_ready = ra; out_b_ready = rb;
    #1;
    exp_rdy = s ? (qb.size() == 0 || rb) : (qa.size() == 0 || ra);
    obs_rdy = in_ready;
    @(posedge clk);
    if (ra && qa.size() != 0) begin void'(qa.pop_front()); ca = (ca + 1) % (1 << CW); end
    if (rb && qb.size() != 0) begin void'(qb.pop_front()); cb = (cb + 1) % (1 << CW); end
    if (v && exp_rdy) begin
      if (s) begin qb.push_back(d); lb = d; end
      else begin qa.push_back(d); la = d; end
    end
    #1;
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete(); la = '0; lb = '0; ca = 0; cb = 0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 32'h1111_0001, 0, 0);
    cycle(1, 1, 32'h2222_0002, 0, 0);
    n_vec++;
    if (!(out_a_valid && out_b_valid)) begin
      n_err++; $display("FAIL reset_prefill: valids a=%b b=%b, required 1 1", out_a_valid, out_b_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({out_a_valid, out_b_valid, out_a_data, out_b_data} !== 66'd0) begin
      n_err++; $display("FAIL reset_async: va=%b vb=%b da=%h db=%h, required all 0", out_a_valid, out_b_valid, out_a_data, out_b_data);
    end
`ifdef DEMUX_COUNT_EN
    n_vec++;
    if ({cnt_a, cnt_b} !== '0) begin
      n_err++; $display("FAIL reset_cnt: cnt_a=%0d cnt_b=%0d, required 0 0", cnt_a, cnt_b);
    end
`endif
    model_clear();
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_route();
    cycle(1, 0, 32'hDEADBEEF, 1, 1);
    n_vec++;
    if (out_a_valid !== 1'b1 || out_a_data !== 32'hDEADBEEF || out_b_valid !== 1'b0) begin
      n_err++; $display("FAIL route_a: va=%b da=%h vb=%b, required 1 deadbeef 0", out_a_valid, out_a_data, out_b_valid);
    end
    cycle(1, 1, 32'h12345678, 1, 1);
    n_vec++;
    if (out_b_valid !== 1'b1 || out_b_data !== 32'h12345678 || out_a_valid !== 1'b0 || out_a_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL route_b: vb=%b db=%h va=%b da=%h, required 1 12345678 0 deadbeef", out_b_valid, out_b_data, out_a_valid, out_a_data);
    end
    cycle(0, 0, 32'h0, 1, 1);
    n_vec++;
    if (out_b_valid !== 1'b0 || out_b_data !== 32'h12345678) begin
      n_err++; $display("FAIL route_drain: vb=%b db=%h, required 0 12345678", out_b_valid, out_b_data);
    end
  endtask

  task automatic test_backpressure();
    cycle(1, 0, 32'h1, 0, 1);
    cycle(1, 0, 32'h2, 0, 1);
    n_vec++;
    if (obs_rdy !== 1'b0 || out_a_data !== 32'h1 || out_a_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_stall: in_ready=%b va=%b da=%h, required 0 1 1", obs_rdy, out_a_valid, out_a_data);
    end
    cycle(1, 0, 32'h2, 1, 1);
    n_vec++;
    if (obs_rdy !== 1'b1 || out_a_valid !== 1'b1 || out_a_data !== 32'h2) begin
      n_err++; $display("FAIL bp_release: in_ready=%b va=%b da=%h, required 1 1 2", obs_rdy, out_a_valid, out_a_data);
    end
    cycle(0, 0, 32'h0, 1, 1);
  endtask

  task automatic test_independence();
    cycle(1, 0, 32'h77, 0, 1);
    cycle(1, 1, 32'hAAAA, 0, 0);
    n_vec++;
    if (obs_rdy !== 1'b1 || out_b_valid !== 1'b1 || out_b_data !== 32'hAAAA || out_a_valid !== 1'b1 || out_a_data !== 32'h77) begin
      n_err++; $display("FAIL indep: in_ready=%b vb=%b db=%h va=%b da=%h, required 1 1 aaaa 1 77", obs_rdy, out_b_valid, out_b_data, out_a_valid, out_a_data);
    end
    cycle(0, 1, 32'h0, 1, 1);
    n_vec++;
    if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin
      n_err++; $display("FAIL indep_drain: va=%b vb=%b, required 0 0", out_a_valid, out_b_valid);
    end
  endtask

  task automatic test_drain_refill();
    cycle(1, 0, 32'h5, 0, 0);
    cycle(1, 0, 32'h6, 1, 0);
    n_vec++;
    if (obs_rdy !== 1'b1 || out_a_valid !== 1'b1 || out_a_data !== 32'h6) begin
      n_err++; $display("FAIL refill: in_ready=%b va=%b da=%h, required 1 1 6", obs_rdy, out_a_valid, out_a_data);
    end
    cycle(0, 0, 32'h0, 1, 1);
  endtask

  task automatic test_counter();
`ifdef DEMUX_COUNT_EN
    rst = 1'b1; #1 model_clear(); @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 17; i++) cycle(1, 0, 32'(i), 1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'(100 + i), 1, 1);
    cycle(0, 0, 32'h0, 1, 1);
    n_vec++;
    if (cnt_a !== 4'd1 || cnt_b !== 4'd3) begin
      n_err++; $display("FAIL counter_wrap: cnt_a=%0d cnt_b=%0d, required 1 3", cnt_a, cnt_b);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      n_vec++;
      if (obs_rdy !== exp_rdy) begin
        n_err++; $display("FAIL rand_ready[%0d]: got %b, required %b", i, obs_rdy, exp_rdy);
      end
      n_vec++;
      if (out_a_valid !== (qa.size() != 0) || out_a_data !== la || out_b_valid !== (qb.size() != 0) || out_b_data !== lb) begin
        n_err++; $display("FAIL rand_out[%0d]: va=%b da=%h vb=%b db=%h, required %b %h %b %h", i,
          out_a_valid, out_a_data, out_b_valid, out_b_data, qa.size() != 0, la, qb.size() != 0, lb);
      end
`ifdef DEMUX_COUNT_EN
      n_vec++;
      if (int'(cnt_a) != ca || int'(cnt_b) != cb) begin
        n_err++; $display("FAIL rand_cnt[%0d]: cnt_a=%0d cnt_b=%0d, required %0d %0d", i, cnt_a, cnt_b, ca, cb);
      end
`endif
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++;
    if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0 || out_a_data !== '0 || out_b_data !== '0) begin
      n_err++; $display("FAIL reset_init: va=%b vb=%b da=%h db=%h, required 0 0 0 0", out_a_valid, out_b_valid, out_a_data, out_b_data);
    end
    test_route();
    test_backpressure();
    test_independence();
    test_drain_refill();
    test_random();
    test_reset();
    test_route();
    test_counter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
